// File: rtl/secp256k1_point_check.sv
// secp256k1_point_check
//
// Sequential on-curve validator for secp256k1 affine points. Decides whether
// y^2 == x^3 + 7 (mod p), p = 2^256 - 2^32 - 977, using one bit-serial
// MSB-first interleaved modular multiplier that is reused for X*X, T*X and Y*Y.
// A check takes 770 edges from the edge that accepts start to the done cycle.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-low reset
//   start     request, sampled only while idle
//   x_in      affine x, captured on an accepted start
//   y_in      affine y, captured on an accepted start
//   busy      high whenever the FSM is not idle
//   done      one-cycle pulse, on_curve valid
//   on_curve  verdict, held from done until the next accepted start
//
// Build option:
//   SECP_RANGE_CHECK_EN  when defined, a start with x_in >= p or y_in >= p is
//                        rejected without running the multiplies (done after
//                        two edges, on_curve = 0). When undefined, each
//                        coordinate is reduced once at capture instead.
//
// state   | meaning
// --------+-----------------------------------------------------
// IDLE    | waiting for start; captures operands on start
// MUL_XX  | T = X * X, 256 iterations
// MUL_XXX | T = T * X, 256 iterations
// MUL_YY  | S = Y * Y, 256 iterations
// COMPARE | U = T + 7 mod p, register verdict (U == S), raise done
// DONE    | done high for this single cycle, then back to IDLE

module secp256k1_point_check (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] x_in,
    input  logic [255:0] y_in,
    output logic         busy,
    output logic         done,
    output logic         on_curve
);

    localparam logic [255:0] P   = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [257:0] P_W = {2'b00, P};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_XX  = 3'd1,
        MUL_XXX = 3'd2,
        MUL_YY  = 3'd3,
        COMPARE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t       state;
    logic [255:0] x_reg;
    logic [255:0] y_reg;
    logic [255:0] t_reg;
    logic [255:0] s_reg;
    logic [255:0] acc;
    logic [7:0]   cnt;
`ifdef SECP_RANGE_CHECK_EN
    logic         reject_q;
    logic         out_of_range;
`endif

    logic [255:0] mul_a;
    logic [255:0] mul_b;
    logic [7:0]   bit_idx;
    logic         mul_bit;
    logic [257:0] dbl;
    logic [257:0] dbl_red;
    logic [257:0] sum;
    logic [257:0] sum_red;
    logic [255:0] acc_next;
    logic [257:0] u_sum;
    logic [257:0] u_red;
    logic         match;
    logic [255:0] x_cap;
    logic [255:0] y_cap;
    logic [1:0]   unused_hi;

    // Operand routing for the shared multiplier.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            MUL_XX:  begin mul_a = x_reg; mul_b = x_reg; end
            MUL_XXX: begin mul_a = t_reg; mul_b = x_reg; end
            MUL_YY:  begin mul_a = y_reg; mul_b = y_reg; end
            default: begin mul_a = '0;    mul_b = '0;    end
        endcase
    end

    // One interleaved step: acc <- 2*acc mod p, then acc <- acc + a mod p when
    // the current bit of b is set. acc < p and a < p, so one conditional
    // subtraction after each operation keeps the result below p.
    always_comb begin
        bit_idx = 8'd255 - cnt;
        mul_bit = mul_b[bit_idx];
        dbl     = {1'b0, acc, 1'b0};
        dbl_red = (dbl >= P_W) ? (dbl - P_W) : dbl;
        sum     = mul_bit ? (dbl_red + {2'b00, mul_a}) : dbl_red;
        sum_red = (sum >= P_W) ? (sum - P_W) : sum;
        acc_next = sum_red[255:0];
    end

    always_comb begin
        u_sum = {2'b00, t_reg} + 258'd7;
        u_red = (u_sum >= P_W) ? (u_sum - P_W) : u_sum;
        match = (u_red == {2'b00, s_reg});
    end

    // Any 256-bit value is below 2p, so a single subtraction fully reduces it.
    always_comb begin
        x_cap = (x_in >= P) ? (x_in - P) : x_in;
        y_cap = (y_in >= P) ? (y_in - P) : y_in;
    end

    // After reduction the top two bits of every intermediate are zero.
    assign unused_hi = sum_red[257:256] | u_red[257:256];

`ifdef SECP_RANGE_CHECK_EN
    assign out_of_range = (x_in >= P) || (y_in >= P);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            on_curve <= 1'b0;
            x_reg    <= '0;
            y_reg    <= '0;
            t_reg    <= '0;
            s_reg    <= '0;
            acc      <= '0;
            cnt      <= '0;
`ifdef SECP_RANGE_CHECK_EN
            reject_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        x_reg    <= x_cap;
                        y_reg    <= y_cap;
                        on_curve <= 1'b0;
                        busy     <= 1'b1;
                        acc      <= '0;
                        cnt      <= '0;
`ifdef SECP_RANGE_CHECK_EN
                        // Rejected operands skip straight to the verdict cycle,
                        // which forces on_curve low.
                        reject_q <= out_of_range;
                        state    <= out_of_range ? COMPARE : MUL_XX;
`else
                        state    <= MUL_XX;
`endif
                    end
                end
                MUL_XX, MUL_XXX, MUL_YY: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == 8'd255) begin
                        // Last bit: store the product and restart the
                        // accumulator so the next multiply follows with no gap.
                        acc <= '0;
                        case (state)
                            MUL_XX:  begin t_reg <= acc_next; state <= MUL_XXX; end
                            MUL_XXX: begin t_reg <= acc_next; state <= MUL_YY;  end
                            default: begin s_reg <= acc_next; state <= COMPARE; end
                        endcase
                    end else begin
                        acc <= acc_next;
                    end
                end
                COMPARE: begin
`ifdef SECP_RANGE_CHECK_EN
                    on_curve <= match && !reject_q;
`else
                    on_curve <= match;
`endif
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secp256k1_point_check.sv
// Testbench for secp256k1_point_check (default build, range check disabled).
// Expected verdicts are pushed to a queue when a start is driven and popped
// when done is seen; latency and busy are checked alongside.

module tb_secp256k1_point_check;

    localparam logic [255:0] P  = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [255:0] GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    // done is seen after edge E769, i.e. 769 edges after the accepting edge E0.
    localparam int LAT = 769;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [255:0] x_in;
    logic [255:0] y_in;
    logic         busy;
    logic         done;
    logic         on_curve;

    int   total = 0;
    int   bad   = 0;
    logic exp_q[$];

    secp256k1_point_check dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .x_in     (x_in),
        .y_in     (y_in),
        .busy     (busy),
        .done     (done),
        .on_curve (on_curve)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called while idle; returns #1 after the accepting edge E0.
    task automatic start_op(input logic [255:0] x, input logic [255:0] y, input logic exp);
        x_in  = x;
        y_in  = y;
        start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done (bounded). Optionally pulses start with other operands so
    // that it is sampled at edge E<inject_at>. Returns #1 after the done edge.
    task automatic wait_done(input string tag, input int inject_at,
                             input logic [255:0] ix, input logic [255:0] iy);
        int   n       = 0;
        logic busy_ok = 1'b1;
        logic got     = 1'b0;
        logic e;
        while (n < 2000 && !got) begin
            if (inject_at != 0 && n == inject_at - 1) begin
                x_in  = ix;
                y_in  = iy;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
            if (inject_at != 0 && n == inject_at) start = 1'b0;
            if (!busy) busy_ok = 1'b0;
            got = done;
        end
        start = 1'b0;
        check({tag, "_latency"}, 256'(n), 256'(LAT));
        check({tag, "_busy"}, 256'(busy_ok), 256'(1));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        check({tag, "_on_curve"}, 256'(on_curve), 256'(e));
    endtask

    // One edge after done: the pulse is gone and the FSM is idle again.
    task automatic after_done(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_done_cleared"}, 256'(done), 256'(0));
        check({tag, "_idle"}, 256'(busy), 256'(0));
    endtask

    initial begin
        logic quiet;
        reset = 1'b0;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_on_curve", 256'(on_curve), 256'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;

        start_op(GX, GY, 1'b1);
        wait_done("gen", 0, '0, '0);
        after_done("gen");

        start_op(GX, GY + 256'd1, 1'b0);
        wait_done("gen_y_plus1", 0, '0, '0);
        after_done("gen_y_plus1");

        start_op('0, '0, 1'b0);
        wait_done("zero", 0, '0, '0);
        after_done("zero");

        // (x, p - y) is the negation of G and also lies on the curve.
        start_op(GX, P - GY, 1'b1);
        wait_done("neg_gen", 0, '0, '0);
        after_done("neg_gen");

        // x = p reduces to 0 at capture: 7 != Gy^2.
        start_op(P, GY, 1'b0);
        wait_done("x_eq_p", 0, '0, '0);
        after_done("x_eq_p");

        // Start at E100 with an off-curve point must be ignored.
        start_op(GX, GY, 1'b1);
        wait_done("ignore_busy_start", 100, GX, GY + 256'd1);

        // Request raised in the DONE cycle; accepted at the first IDLE edge.
        x_in  = GX;
        y_in  = GY + 256'd1;
        start = 1'b1;
        exp_q.push_back(1'b0);
        @(posedge clk);
        #1;
        check("restart_idle_busy", 256'(busy), 256'(0));
        check("restart_idle_done", 256'(done), 256'(0));
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("restart", 0, '0, '0);
        after_done("restart");

        // Reset asserted so that edge E300 samples it.
        start_op(GX, GY, 1'b1);
        repeat (299) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", 256'(busy), 256'(0));
        check("midrst_on_curve", 256'(on_curve), 256'(0));
        check("midrst_done", 256'(done), 256'(0));
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        reset = 1'b1;

        // No start for 1000 cycles: outputs stay low, no stray done.
        quiet = 1'b1;
        repeat (1000) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || done !== 1'b0 || on_curve !== 1'b0) quiet = 1'b0;
        end
        check("idle_1000_quiet", 256'(quiet), 256'(1));

        start_op(GX, GY, 1'b1);
        wait_done("gen_after_rst", 0, '0, '0);
        after_done("gen_after_rst");

        check("scoreboard_empty", 256'(exp_q.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
